addmult_issuer: RTL

ADDMULT_ISSUER -- requirements
Module: addmult_issuer

---
 rtl/addmult_issuer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/addmult_issuer.sv
`default_nettype none
// ============================================================================
// Module  : addmult_issuer
// Purpose : Issues one (l+r)*m request at a time to an add-multiply unit,
//           returns its result (or a qNaN on timeout) with the request tag.
// Rev     : 1.0
// ============================================================================
module addmult_issuer #(
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_add_left,
    input  logic [63:0]      req_add_right,
    input  logic [63:0]      req_mult_right,
    input  logic [TAG_W-1:0] req_tag,
    output logic [63:0]      am_add_left,
    output logic [63:0]      am_add_right,
    output logic [63:0]      am_mult_right,
    output logic             am_input_valid,
    input  logic [63:0]      am_result,
    input  logic             am_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_stray,
    input  logic             err_clear,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);
    localparam logic [63:0] c_qnan     = 64'h7FF8_0000_0000_0000;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [63:0]        left_q, left_d;
    logic [63:0]        right_q, right_d;
    logic [63:0]        mult_q, mult_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [63:0]        res_q, res_d;
    logic               tmo_q, tmo_d;
    logic               err_tmo_q, err_tmo_d;
    logic               err_stray_q, err_stray_d;
    logic [15:0]        opcnt_q, opcnt_d;
    logic               w_tmo_evt;
    logic               w_stray_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            mult_q      <= '0;
            tag_q       <= '0;
            res_q       <= '0;
            tmo_q       <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_stray_q <= 1'b0;
            opcnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            mult_q      <= mult_d;
            tag_q       <= tag_d;
            res_q       <= res_d;
            tmo_q       <= tmo_d;
            err_tmo_q   <= err_tmo_d;
            err_stray_q <= err_stray_d;
            opcnt_q     <= opcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        right_d   = right_q;
        mult_d    = mult_q;
        tag_d     = tag_q;
        res_d     = res_q;
        tmo_d     = tmo_q;
        opcnt_d   = opcnt_q;
        w_tmo_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    left_d  = req_add_left;
                    right_d = req_add_right;
                    mult_d  = req_mult_right;
                    tag_d   = req_tag;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the last wait cycle beats the timeout.
                if (am_done) begin
                    res_d   = am_result;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == c_tmo_last) begin
                    res_d     = c_qnan;
                    tmo_d     = 1'b1;
                    w_tmo_evt = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    opcnt_d = opcnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Set events take priority over a simultaneous clear.
    assign w_stray_evt = am_done && (state_q != S_WAIT);
    assign err_tmo_d   = w_tmo_evt   | (err_tmo_q   & ~err_clear);
    assign err_stray_d = w_stray_evt | (err_stray_q & ~err_clear);

    assign req_ready      = reset && (state_q == S_IDLE);
    assign am_input_valid = (state_q == S_ISSUE);
    assign am_add_left    = left_q;
    assign am_add_right   = right_q;
    assign am_mult_right  = mult_q;
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_result     = res_q;
    assign rsp_tag        = tag_q;
    assign rsp_timeout    = tmo_q;
    assign busy           = (state_q != S_IDLE);
    assign err_timeout    = err_tmo_q;
    assign err_stray      = err_stray_q;
    assign op_count       = opcnt_q;

endmodule
`default_nettype wire
